// File: rtl/div_ctrl.sv
// div_ctrl: keypad sequencer for the 4-bit restoring divider.
// Builds BCD operands, validates them, starts the divider, captures results.
`timescale 1ns/1ps
module div_ctrl #(
    parameter int DIV_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic [3:0] div_q,
    input  logic [3:0] div_r,
    output logic [7:0] a_bcd,
    output logic [7:0] b_bcd,
    output logic       div_start,
    output logic [3:0] result_q,
    output logic [3:0] result_r,
    output logic       result_valid,
    output logic       err,
    output logic       busy
);

    localparam int CW = (DIV_LAT < 1) ? 1 : $clog2(DIV_LAT + 1);

    typedef enum logic [2:0] {
        ENT_A,
        ENT_B,
        START,
        WAIT,
        DONE,
        ERR
    } state_t;

    state_t        state;
    logic [1:0]    a_cnt;
    logic [1:0]    b_cnt;
    logic [CW-1:0] wcnt;

    logic is_digit;
    logic is_div;
    logic is_eq;
    logic is_clr;
    logic a_ok;
    logic b_ok;
    logic b_zero;

    function automatic logic in_range(input logic [7:0] v);
        in_range = (v[7:4] == 4'd0) ||
                   ((v[7:4] == 4'd1) && (v[3:0] <= 4'd5));
    endfunction

    // Key decode and operand range checks
    always_comb begin
        is_digit = key_valid && (key_code <= 4'd9);
        is_div   = key_valid && (key_code == 4'hA);
        is_eq    = key_valid && (key_code == 4'hB);
        is_clr   = key_valid && (key_code == 4'hC);
        a_ok     = in_range(a_bcd);
        b_ok     = in_range(b_bcd);
        b_zero   = (b_bcd == 8'h00);
    end

    // Sequencer FSM with registered outputs; clear overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ENT_A;
            a_bcd        <= 8'h00;
            b_bcd        <= 8'h00;
            a_cnt        <= 2'd0;
            b_cnt        <= 2'd0;
            wcnt         <= '0;
            div_start    <= 1'b0;
            result_q     <= 4'h0;
            result_r     <= 4'h0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            busy         <= 1'b0;
        end else begin
            div_start <= 1'b0;
            if (is_clr) begin
                state        <= ENT_A;
                a_bcd        <= 8'h00;
                b_bcd        <= 8'h00;
                a_cnt        <= 2'd0;
                b_cnt        <= 2'd0;
                wcnt         <= '0;
                result_q     <= 4'h0;
                result_r     <= 4'h0;
                result_valid <= 1'b0;
                err          <= 1'b0;
                busy         <= 1'b0;
            end else begin
                unique case (state)
                    ENT_A: begin
                        if (is_digit) begin
                            if (a_cnt == 2'd0) begin
                                a_bcd <= {4'h0, key_code};
                                a_cnt <= 2'd1;
                            end else if (a_cnt == 2'd1) begin
                                a_bcd <= {a_bcd[3:0], key_code};
                                a_cnt <= 2'd2;
                            end
                        end else if (is_div && (a_cnt != 2'd0)) begin
                            if (!a_ok) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else begin
                                state <= ENT_B;
                                b_bcd <= 8'h00;
                                b_cnt <= 2'd0;
                            end
                        end
                    end
                    ENT_B: begin
                        if (is_digit) begin
                            if (b_cnt == 2'd0) begin
                                b_bcd <= {4'h0, key_code};
                                b_cnt <= 2'd1;
                            end else if (b_cnt == 2'd1) begin
                                b_bcd <= {b_bcd[3:0], key_code};
                                b_cnt <= 2'd2;
                            end
                        end else if (is_eq && (b_cnt != 2'd0)) begin
                            if (!a_ok || !b_ok || b_zero) begin
                                state <= ERR;
                                err   <= 1'b1;
                            end else begin
                                state     <= START;
                                div_start <= 1'b1;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        state <= WAIT;
                        wcnt  <= '0;
                    end
                    WAIT: begin
                        if (wcnt == CW'(DIV_LAT)) begin
                            state        <= DONE;
                            result_q     <= div_q;
                            result_r     <= div_r;
                            result_valid <= 1'b1;
                            busy         <= 1'b0;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    DONE, ERR: begin
                        if (is_digit) begin
                            state        <= ENT_A;
                            a_bcd        <= {4'h0, key_code};
                            a_cnt        <= 2'd1;
                            b_bcd        <= 8'h00;
                            b_cnt        <= 2'd0;
                            result_q     <= 4'h0;
                            result_r     <= 4'h0;
                            result_valid <= 1'b0;
                            err          <= 1'b0;
                        end
                    end
                    default: state <= ENT_A;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed bench for div_ctrl.
// A behavioural divider answers from the operand outputs.
`timescale 1ns/1ps
module tb_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [3:0] div_q;
    logic [3:0] div_r;
    logic [7:0] a_bcd;
    logic [7:0] b_bcd;
    logic       div_start;
    logic [3:0] result_q;
    logic [3:0] result_r;
    logic       result_valid;
    logic       err;
    logic       busy;
    logic [27:0] outs;

    int checks = 0;
    int errors = 0;
    int av;
    int bv;

    div_ctrl #(.DIV_LAT(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_valid(key_valid),
        .key_code(key_code),
        .div_q(div_q),
        .div_r(div_r),
        .a_bcd(a_bcd),
        .b_bcd(b_bcd),
        .div_start(div_start),
        .result_q(result_q),
        .result_r(result_r),
        .result_valid(result_valid),
        .err(err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    assign outs = {a_bcd, b_bcd, div_start, result_q, result_r,
                   result_valid, err, busy};

    // Divider stand-in: BCD operands to binary quotient/remainder
    always_comb begin
        av = int'(a_bcd[7:4]) * 10 + int'(a_bcd[3:0]);
        bv = int'(b_bcd[7:4]) * 10 + int'(b_bcd[3:0]);
        if (bv != 0) begin
            div_q = 4'(av / bv);
            div_r = 4'(av % bv);
        end else begin
            div_q = 4'hF;
            div_r = 4'hF;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic [3:0] c);
        key_valid = 1'b1;
        key_code  = c;
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic run_eq(input string tag, input logic [3:0] eq,
                          input logic [3:0] er);
        int lat;
        int ns;
        int nb;
        logic stab;
        logic [7:0] a0;
        logic [7:0] b0;
        key(4'hB);
        chk({tag, "_start_k1"}, div_start, 1);
        lat  = 1;
        ns   = 0;
        nb   = 0;
        stab = 1'b1;
        a0   = a_bcd;
        b0   = b_bcd;
        while (!result_valid && lat < 20) begin
            ns += int'(div_start);
            nb += int'(busy);
            if (a_bcd !== a0 || b_bcd !== b0) stab = 1'b0;
            cyc(1);
            lat++;
        end
        chk({tag, "_latency"}, lat, 7);
        chk({tag, "_starts"}, ns, 1);
        chk({tag, "_busy_cycles"}, nb, 6);
        chk({tag, "_operand_hold"}, stab, 1);
        chk({tag, "_q"}, result_q, eq);
        chk({tag, "_r"}, result_r, er);
        chk({tag, "_busy_done"}, busy, 0);
    endtask

    initial begin
        int ns;
        int nv;

        // reset
        cyc(2);
        chk("reset_outs", outs, 0);
        rst_n = 1'b1;
        cyc(1);

        // 13 / 4
        key(4'h1);
        key(4'h3);
        chk("a_13", a_bcd, 8'h13);
        key(4'hB);
        chk("eq_in_ent_a", {busy, err, div_start}, 0);
        key(4'hE);
        chk("ignored_key_a", a_bcd, 8'h13);
        key(4'hA);
        key(4'h4);
        chk("b_04", b_bcd, 8'h04);
        key(4'hA);
        chk("div_in_ent_b", {b_bcd, busy, err}, {8'h04, 2'b00});
        run_eq("d13_4", 4'd3, 4'd1);

        // 15 / 15, then 9 / 2
        key(4'h1);
        chk("done_digit", {result_valid, result_q, result_r}, 0);
        chk("done_digit_a", {a_bcd, b_bcd}, {8'h01, 8'h00});
        key(4'h5);
        key(4'hA);
        key(4'h1);
        key(4'h5);
        run_eq("d15_15", 4'd1, 4'd0);
        key(4'h9);
        key(4'hA);
        key(4'h2);
        run_eq("d9_2", 4'd4, 4'd1);

        // divide by zero
        key(4'h9);
        key(4'hA);
        key(4'h0);
        key(4'hB);
        chk("dz_err", {err, div_start, busy}, 3'b100);
        chk("dz_result", {result_q, result_r, result_valid}, 0);
        cyc(1);
        chk("dz_no_start", div_start, 0);
        key(4'h7);
        chk("dz_recover", {a_bcd, b_bcd, err}, {8'h07, 8'h00, 1'b0});

        // range errors and digit limit
        key(4'hC);
        chk("clr_a", a_bcd, 8'h00);
        key(4'hA);
        chk("empty_div", {err, busy}, 0);
        key(4'h1);
        key(4'h6);
        key(4'hA);
        chk("a16_err", err, 1);
        key(4'h2);
        key(4'h0);
        chk("a20", {a_bcd, err}, {8'h20, 1'b0});
        key(4'hA);
        chk("a20_err", err, 1);
        key(4'h1);
        key(4'h2);
        key(4'h7);
        chk("third_digit", {a_bcd, err}, {8'h12, 1'b0});

        // 12 / 5 aborted by clear at K+4
        key(4'hA);
        key(4'h5);
        key(4'hB);
        chk("abort_start", div_start, 1);
        cyc(3);
        chk("abort_busy_k4", busy, 1);
        key(4'hC);
        chk("abort_state", {busy, a_bcd, b_bcd, result_valid}, 0);
        ns = 0;
        nv = 0;
        repeat (12) begin
            ns += int'(div_start);
            nv += int'(result_valid);
            cyc(1);
        end
        chk("abort_no_start", ns, 0);
        chk("abort_no_valid", nv, 0);

        // async reset at K+3
        key(4'h9);
        key(4'hA);
        key(4'h4);
        key(4'hB);
        cyc(2);
        rst_n = 1'b0;
        #1;
        chk("rst_midwait", outs, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ns = 0;
        nv = 0;
        repeat (12) begin
            ns += int'(div_start);
            nv += int'(result_valid);
            cyc(1);
        end
        chk("rst_no_capture", nv + ns, 0);
        key(4'h8);
        key(4'hA);
        key(4'h3);
        run_eq("d8_3", 4'd2, 4'd2);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
